// File: rtl/bp_cce_mem_to_io_split_pkg.sv
// Shared BedRock memory-message types and helpers for the block-to-beat splitter.
// Contents:
//   - processor configuration localparams (address, block, LCE id and way widths)
//   - message type / size enums, header and full message structs
//   - bedrock_size_to_bytes(): message size code to byte count
//   - bedrock_is_read(): true for commands that return block data
package bp_cce_mem_to_io_split_pkg;

   localparam int unsigned paddr_width     = 40;
   localparam int unsigned cce_block_width = 512;
   localparam int unsigned lce_id_width    = 4;
   localparam int unsigned lce_assoc       = 8;
   localparam int unsigned way_id_width    = $clog2(lce_assoc);

   localparam int unsigned beat_bytes = 8;
   localparam int unsigned max_beats  = cce_block_width / 64;
   localparam int unsigned beat_width = $clog2(max_beats) + 1;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [lce_id_width-1:0] lce_id;
      logic [way_id_width-1:0] way_id;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_payload_s payload;
      bp_bedrock_msg_size_e    size;
      logic [paddr_width-1:0]  addr;
      bp_bedrock_mem_type_e    msg_type;
   } bp_bedrock_mem_header_s;

   typedef struct packed {
      logic [cce_block_width-1:0] data;
      bp_bedrock_mem_header_s     header;
   } bp_bedrock_mem_msg_s;

   localparam int unsigned cce_mem_msg_width = $bits(bp_bedrock_mem_msg_s);

   function automatic int unsigned bedrock_size_to_bytes(input bp_bedrock_msg_size_e size);
      return 32'd1 << size;
   endfunction

   function automatic logic bedrock_is_read(input bp_bedrock_mem_type_e msg_type);
      return (msg_type == e_bedrock_mem_rd) || (msg_type == e_bedrock_mem_uc_rd);
   endfunction

endpackage

// File: rtl/bp_me_wrap_addr_gen.sv
// Wrapped beat address generator (purely combinational).
// The low log2(size_bytes) address bits advance by 8 bytes per beat and wrap within the
// size-aligned window, so a burst starts at the requested word (critical word first).
// Ports:
//   base_addr  in   request address
//   size       in   request size code
//   beat       in   beat index
//   beat_addr  out  address of the given beat
module bp_me_wrap_addr_gen
   import bp_cce_mem_to_io_split_pkg::*;
(
   input  logic [paddr_width-1:0] base_addr,
   input  bp_bedrock_msg_size_e   size,
   input  logic [beat_width-1:0]  beat,
   output logic [paddr_width-1:0] beat_addr
);

   logic [paddr_width-1:0] window_mask;
   logic [paddr_width-1:0] advanced;

   always_comb begin
      window_mask = (paddr_width'(1) << size) - paddr_width'(1);
      advanced    = base_addr + paddr_width'({beat, 3'b000});
      // Upper bits come from the request, the in-window offset from the advanced address.
      beat_addr   = (base_addr & ~window_mask) | (advanced & window_mask);
   end

endmodule

// File: rtl/bp_cce_mem_to_io_split.sv
// Splits one block-granular memory command into a sequence of 64-bit I/O commands and
// assembles the I/O responses into a single block-granular memory response.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   mem_cmd_i/_v_i/_ready_o block command in (valid/ready)
//   mem_resp_o/_v_o/_yumi_i block response out (valid/yumi)
//   io_cmd_o/_v_o/_ready_i  narrow command out, only data[63:0] meaningful
//   io_resp_i/_v_i/_yumi_o  narrow response in, read data in data[63:0]
module bp_cce_mem_to_io_split
   import bp_cce_mem_to_io_split_pkg::*;
(
   input  logic                clk_i,
   input  logic                reset_i,
   input  bp_bedrock_mem_msg_s mem_cmd_i,
   input  logic                mem_cmd_v_i,
   output logic                mem_cmd_ready_o,
   output bp_bedrock_mem_msg_s mem_resp_o,
   output logic                mem_resp_v_o,
   input  logic                mem_resp_yumi_i,
   output bp_bedrock_mem_msg_s io_cmd_o,
   output logic                io_cmd_v_o,
   input  logic                io_cmd_ready_i,
   input  bp_bedrock_mem_msg_s io_resp_i,
   input  logic                io_resp_v_i,
   output logic                io_resp_yumi_o
);

   typedef enum logic [1:0] {e_ready, e_send, e_wait, e_resp} state_e;

   localparam int unsigned lane_width = $clog2(max_beats);
   localparam int unsigned bit_width  = $clog2(cce_block_width);

   state_e                     state_r;
   bp_bedrock_mem_header_s     header_r;
   logic [cce_block_width-1:0] data_r;
   logic [beat_width-1:0]      beat_r;

   int unsigned            size_bytes;
   int unsigned            size_beats;
   logic                   is_narrow;
   logic                   is_read;
   logic [beat_width-1:0]  last_beat;
   logic [63:0]            resp_mask;
   logic [lane_width-1:0]  lane;
   logic [bit_width-1:0]   lane_base;
   logic [paddr_width-1:0] beat_addr;
   logic                   unused_io_resp;

   bp_me_wrap_addr_gen addr_gen (
      .base_addr (header_r.addr),
      .size      (header_r.size),
      .beat      (beat_r),
      .beat_addr (beat_addr)
   );

   // beat_r stays below max_beats, so its low bits select the data lane directly.
   assign lane      = beat_r[lane_width-1:0];
   assign lane_base = {lane, 6'b000000};

   always_comb begin
      size_bytes = bedrock_size_to_bytes(header_r.size);
      is_narrow  = size_bytes < beat_bytes;
      is_read    = bedrock_is_read(header_r.msg_type);
      if (is_narrow) begin
         size_beats = 1;
      end else if (size_bytes / beat_bytes > max_beats) begin
         size_beats = max_beats;
      end else begin
         size_beats = size_bytes / beat_bytes;
      end
      last_beat = beat_width'(size_beats - 1);
      // Sub-beat reads keep only the requested low bytes of lane 0.
      resp_mask = '1;
      if (is_narrow) begin
         resp_mask = (64'd1 << (size_bytes * 8)) - 64'd1;
      end
   end

   always_comb begin
      io_cmd_o             = '0;
      io_cmd_o.header      = header_r;
      io_cmd_o.header.addr = beat_addr;
      if (!is_narrow) begin
         io_cmd_o.header.size = e_bedrock_msg_size_8;
      end
      if (!is_read) begin
         io_cmd_o.data[63:0] = data_r[lane_base +: 64];
      end
   end

   always_comb begin
      mem_resp_o        = '0;
      mem_resp_o.header = header_r;
      if (is_read) begin
         mem_resp_o.data = data_r;
      end
   end

   assign mem_cmd_ready_o = (state_r == e_ready);
   assign io_cmd_v_o      = (state_r == e_send);
   assign mem_resp_v_o    = (state_r == e_resp);
   assign io_resp_yumi_o  = io_resp_v_i & (state_r == e_wait);

   // Only read data is taken from the narrow response.
   assign unused_io_resp = ^{io_resp_i.header, io_resp_i.data[cce_block_width-1:64]};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r  <= e_ready;
         header_r <= '0;
         data_r   <= '0;
         beat_r   <= '0;
      end else begin
         unique case (state_r)
            e_ready: begin
               if (mem_cmd_v_i) begin
                  header_r <= mem_cmd_i.header;
                  // Reads start from a clean buffer so unused lanes return zero.
                  data_r   <= bedrock_is_read(mem_cmd_i.header.msg_type) ? '0 : mem_cmd_i.data;
                  beat_r   <= '0;
                  state_r  <= e_send;
               end
            end
            e_send: begin
               if (io_cmd_ready_i) begin
                  state_r <= e_wait;
               end
            end
            e_wait: begin
               if (io_resp_v_i) begin
                  if (is_read) begin
                     data_r[lane_base +: 64] <= io_resp_i.data[63:0] & resp_mask;
                  end
                  if (beat_r == last_beat) begin
                     state_r <= e_resp;
                  end else begin
                     beat_r  <= beat_r + 1'b1;
                     state_r <= e_send;
                  end
               end
            end
            e_resp: begin
               if (mem_resp_yumi_i) begin
                  state_r <= e_ready;
               end
            end
            default: state_r <= e_ready;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_cce_mem_to_io_split.sv
// Scoreboard bench for bp_cce_mem_to_io_split: a driver issues block commands and pushes
// the expected narrow commands and block response; a monitor process plays the I/O target
// and the response consumer, and pops/compares every handshake it sees.
module tb_bp_cce_mem_to_io_split;
   import bp_cce_mem_to_io_split_pkg::*;

   typedef struct packed {
      bp_bedrock_mem_header_s h;
      logic [63:0]            d;
   } io_exp_s;

   logic                clk = 1'b0;
   logic                reset_i;
   bp_bedrock_mem_msg_s mem_cmd_i;
   logic                mem_cmd_v_i;
   logic                mem_cmd_ready_o;
   bp_bedrock_mem_msg_s mem_resp_o;
   logic                mem_resp_v_o;
   logic                mem_resp_yumi_i;
   bp_bedrock_mem_msg_s io_cmd_o;
   logic                io_cmd_v_o;
   logic                io_cmd_ready_i;
   bp_bedrock_mem_msg_s io_resp_i;
   logic                io_resp_v_i;
   logic                io_resp_yumi_o;

   io_exp_s             exp_io[$];
   bp_bedrock_mem_msg_s exp_resp[$];
   logic [63:0]         pend[$];

   int n_checks = 0;
   int n_pass   = 0;
   int accept_cnt = 0;
   int io_cnt = 0;
   int flush_gen = 0;
   int mode = 0;  // 0 random delays, 1 heavy backpressure, 2 zero-delay target/consumer
   int cyc = 0;
   int accept_cyc = 0;
   int rise_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bp_cce_mem_to_io_split dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .mem_cmd_i       (mem_cmd_i),
      .mem_cmd_v_i     (mem_cmd_v_i),
      .mem_cmd_ready_o (mem_cmd_ready_o),
      .mem_resp_o      (mem_resp_o),
      .mem_resp_v_o    (mem_resp_v_o),
      .mem_resp_yumi_i (mem_resp_yumi_i),
      .io_cmd_o        (io_cmd_o),
      .io_cmd_v_o      (io_cmd_v_o),
      .io_cmd_ready_i  (io_cmd_ready_i),
      .io_resp_i       (io_resp_i),
      .io_resp_v_i     (io_resp_v_i),
      .io_resp_yumi_o  (io_resp_yumi_o)
   );

   task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Target memory contents: a fixed function of the beat address.
   function automatic logic [63:0] tgt_data(input logic [paddr_width-1:0] a);
      return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0] + 32'h1234_5678};
   endfunction

   // Reference model: derive narrow beats and the block response from the request.
   task automatic expect_cmd(input bp_bedrock_mem_msg_s cmd);
      longint unsigned     bytes, beats, a, base, off, ba;
      logic                rd;
      bp_bedrock_mem_msg_s resp;
      io_exp_s             e;
      logic [63:0]         w;
      bytes = longint'(1) << cmd.header.size;
      beats = (bytes < 8) ? 1 : bytes / 8;
      a     = longint'(cmd.header.addr);
      off   = a % bytes;
      base  = a - off;
      rd    = (cmd.header.msg_type == e_bedrock_mem_rd) ||
              (cmd.header.msg_type == e_bedrock_mem_uc_rd);
      resp      = cmd;
      resp.data = '0;
      for (int k = 0; k < int'(beats); k++) begin
         ba       = base + ((off + 8 * longint'(k)) % bytes);
         e.h      = cmd.header;
         e.h.addr = paddr_width'(ba);
         if (bytes >= 8) e.h.size = e_bedrock_msg_size_8;
         e.d = rd ? 64'd0 : cmd.data[64*k +: 64];
         exp_io.push_back(e);
         if (rd) begin
            w = tgt_data(paddr_width'(ba));
            if (bytes < 8) w = w & ((64'd1 << (8 * bytes)) - 64'd1);
            resp.data[64*k +: 64] = w;
         end
      end
      exp_resp.push_back(resp);
   endtask

   task automatic send(input bp_bedrock_mem_msg_s cmd);
      int start;
      int done;
      expect_cmd(cmd);
      start       = accept_cnt;
      done        = 0;
      mem_cmd_i   = cmd;
      mem_cmd_v_i = 1'b1;
      for (int i = 0; i < 400 && done == 0; i++) begin
         @(posedge clk);
         #1;
         if (accept_cnt != start) done = 1;
      end
      mem_cmd_v_i = 1'b0;
      if (done == 0) check("cmd_accept_timeout", 640'(0), 640'(1));
   endtask

   task automatic drain();
      int done;
      done = 0;
      for (int i = 0; i < 5000 && done == 0; i++) begin
         @(posedge clk);
         #1;
         if (exp_io.size() == 0 && exp_resp.size() == 0) done = 1;
      end
      if (done == 0) check("drain_timeout", 640'(exp_resp.size()), 640'(0));
   endtask

   function automatic bp_bedrock_mem_msg_s mk(input bp_bedrock_mem_type_e t,
                                              input bp_bedrock_msg_size_e s,
                                              input logic [paddr_width-1:0] a);
      bp_bedrock_mem_msg_s m;
      m                       = '0;
      m.header.msg_type       = t;
      m.header.size           = s;
      m.header.addr           = a;
      m.header.payload.lce_id = lce_id_width'($urandom);
      m.header.payload.way_id = way_id_width'($urandom);
      for (int i = 0; i < 16; i++) m.data[32*i +: 32] = $urandom;
      return m;
   endfunction

   function automatic bp_bedrock_mem_msg_s rand_cmd();
      bp_bedrock_msg_size_e s;
      logic [paddr_width-1:0] a;
      longint unsigned align;
      s     = bp_bedrock_msg_size_e'($urandom_range(0, 6));
      align = (s < e_bedrock_msg_size_8) ? (longint'(1) << s) : 8;
      a     = {8'($urandom), 32'($urandom)};
      a     = paddr_width'(longint'(a) - (longint'(a) % align));
      return mk(bp_bedrock_mem_type_e'($urandom_range(0, 3)), s, a);
   endfunction

   // Monitor: drives the target/consumer side, then decides and checks handshakes.
   initial begin : monitor
      int seen_flush = 0;
      int resp_delay = 0;
      int resp_wait = 0;
      int resp_need = 0;
      logic resp_taken = 1'b0;
      logic io_hold = 1'b0;
      logic rs_hold = 1'b0;
      logic prev_rv = 1'b0;
      bp_bedrock_mem_msg_s io_held;
      bp_bedrock_mem_msg_s rs_held;
      io_exp_s e;
      bp_bedrock_mem_msg_s r;
      io_cmd_ready_i  = 1'b0;
      io_resp_v_i     = 1'b0;
      io_resp_i       = '0;
      mem_resp_yumi_i = 1'b0;
      forever begin
         @(negedge clk);
         if (flush_gen != seen_flush) begin
            seen_flush  = flush_gen;
            pend.delete();
            io_resp_v_i = 1'b0;
            resp_taken  = 1'b0;
            io_hold     = 1'b0;
            rs_hold     = 1'b0;
            resp_wait   = 0;
         end
         if (resp_taken) begin
            io_resp_v_i = 1'b0;
            resp_taken  = 1'b0;
         end
         if (!io_resp_v_i && pend.size() > 0) begin
            if (resp_delay > 0 && mode != 2) begin
               resp_delay--;
            end else begin
               io_resp_i                 = '0;
               io_resp_i.header.msg_type = e_bedrock_mem_wr;
               io_resp_i.header.addr     = {8'($urandom), 32'($urandom)};
               io_resp_i.data[63:0]      = pend.pop_front();
               io_resp_v_i               = 1'b1;
               resp_delay = (mode == 0) ? int'($urandom_range(0, 2)) :
                            (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            end
         end
         case (mode)
            1:       io_cmd_ready_i = ($urandom_range(0, 2) == 0);
            2:       io_cmd_ready_i = 1'b1;
            default: io_cmd_ready_i = ($urandom_range(0, 3) != 0);
         endcase
         if (mem_resp_v_o) begin
            if (resp_wait == 0) resp_need = (mode == 1) ? 5 : (mode == 2) ? 0 :
                                            int'($urandom_range(0, 2));
            mem_resp_yumi_i = (resp_wait >= resp_need);
            resp_wait++;
         end else begin
            mem_resp_yumi_i = 1'b0;
            resp_wait       = 0;
         end
         #1;
         if (mem_cmd_v_i && mem_cmd_ready_o) begin
            accept_cnt++;
            accept_cyc = cyc;
         end
         if (io_cmd_v_o) begin
            if (io_hold) check("io_cmd_stable", 640'(io_cmd_o), 640'(io_held));
            if (io_cmd_ready_i) begin
               if (exp_io.size() == 0) begin
                  check("io_cmd_unexpected", 640'(io_cmd_o.header), 640'(0));
               end else begin
                  e = exp_io.pop_front();
                  check("io_cmd_header", 640'(io_cmd_o.header), 640'(e.h));
                  check("io_cmd_data", 640'(io_cmd_o.data[63:0]), 640'(e.d));
               end
               pend.push_back(tgt_data(io_cmd_o.header.addr));
               io_cnt++;
               io_hold = 1'b0;
            end else begin
               io_hold = 1'b1;
               io_held = io_cmd_o;
            end
         end else if (io_hold) begin
            check("io_cmd_dropped", 640'(0), 640'(1));
            io_hold = 1'b0;
         end
         if (io_resp_v_i && io_resp_yumi_o) resp_taken = 1'b1;
         if (mem_resp_v_o) begin
            if (!prev_rv) rise_cyc = cyc;
            check("busy_cmd_ready_low", 640'(mem_cmd_ready_o), 640'(0));
            if (rs_hold) check("mem_resp_stable", 640'(mem_resp_o), 640'(rs_held));
            if (mem_resp_yumi_i) begin
               if (exp_resp.size() == 0) begin
                  check("mem_resp_unexpected", 640'(mem_resp_o.header), 640'(0));
               end else begin
                  r = exp_resp.pop_front();
                  check("mem_resp", 640'(mem_resp_o), 640'(r));
               end
               rs_hold = 1'b0;
            end else begin
               rs_hold = 1'b1;
               rs_held = mem_resp_o;
            end
         end
         prev_rv = mem_resp_v_o;
      end
   end

   initial begin : driver
      bp_bedrock_mem_msg_s m;
      int start;
      reset_i     = 1'b1;
      mem_cmd_v_i = 1'b0;
      mem_cmd_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(posedge clk);
      #1;
      check("reset_cmd_ready", 640'(mem_cmd_ready_o), 640'(1));
      check("reset_io_cmd_v", 640'(io_cmd_v_o), 640'(0));
      check("reset_mem_resp_v", 640'(mem_resp_v_o), 640'(0));
      check("reset_io_resp_yumi", 640'(io_resp_yumi_o), 640'(0));
      check("reset_mem_resp", 640'(mem_resp_o), 640'(0));
      check("reset_io_cmd", 640'(io_cmd_o), 640'(0));

      // Zero-delay 64B read: response valid 1 + 2*8 cycles after the command handshake.
      mode = 2;
      send(mk(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h00_8000_0000));
      drain();
      check("mem_resp_latency", 640'(rise_cyc - accept_cyc), 640'(17));

      mode = 0;
      m = mk(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h00_8000_0040);
      for (int k = 0; k < 8; k++) m.data[64*k +: 64] = 64'(k);
      send(m);
      send(mk(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h00_8000_1018));
      send(mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_4, 40'h00_0000_1004));
      drain();

      mode = 1;
      send(mk(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h00_8000_2028));
      send(mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_16, 40'h00_0000_3010));
      send(mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h00_0000_3008));
      drain();

      mode = 0;
      for (int i = 0; i < 40; i++) send(rand_cmd());
      drain();

      // Reset in the middle of a read burst, then a normal command afterwards.
      start = io_cnt;
      send(mk(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h00_8000_4000));
      for (int i = 0; i < 400 && io_cnt < start + 3; i++) @(posedge clk);
      if (io_cnt < start + 3) check("burst_progress_timeout", 640'(io_cnt - start), 640'(3));
      @(posedge clk);
      #2;
      reset_i = 1'b1;
      exp_io.delete();
      exp_resp.delete();
      flush_gen++;
      #1;
      check("midreset_cmd_ready", 640'(mem_cmd_ready_o), 640'(1));
      check("midreset_io_cmd_v", 640'(io_cmd_v_o), 640'(0));
      check("midreset_mem_resp_v", 640'(mem_resp_v_o), 640'(0));
      check("midreset_io_resp_yumi", 640'(io_resp_yumi_o), 640'(0));
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      send(mk(e_bedrock_mem_rd, e_bedrock_msg_size_32, 40'h00_8000_5010));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
      $fatal(1);
   end

endmodule
